rtl_xor_unmask: RTL and testbench

// - Receive side of the XOR masking path: takes masked words (dout = A ^ B) plus key word A,

---
 rtl/rtl_xor_pkg.sv | 12 +
 rtl/rtl_xor_skid2.sv | 75 +++++++
 rtl/rtl_xor_unmask.sv | 78 +++++++
 tb/tb_rtl_xor_unmask.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtl_xor_pkg.sv
// Shared definitions for the XOR masking path: default word/frame sizes and FSM states.
package rtl_xor_pkg;

    localparam int DEFAULT_DATA_WIDTH = 10;
    localparam int DEFAULT_FRAME_LEN  = 8;

    typedef logic [0:0] state_t;

    localparam state_t IDLE   = 1'b0;
    localparam state_t ACTIVE = 1'b1;

endpackage

// File: rtl/rtl_xor_skid2.sv
// Two-entry valid/ready FIFO. The output comes straight from the head register.
// Ready is registered and drops only when both entries are occupied.
module rtl_xor_skid2
    import rtl_xor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_DATA_WIDTH + 1
) (
    input  logic             clk_i,
    input  logic             sreset_n_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             ready_q, ready_d;
    logic             push;
    logic             pop;

    assign push    = valid_i && ready_q;
    assign pop     = valid_o && ready_i;
    assign valid_o = (count_q != 2'd0);
    assign data_o  = head_q;
    assign ready_o = ready_q;

    // Next occupancy and entry contents; a simultaneous push and pop refills the head in place.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = data_i;
                end else begin
                    tail_d = data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                end
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                head_d = data_i;
            end
            default: begin
            end
        endcase
        ready_d = (count_d != 2'd2);
    end

    // Register the FIFO state; reset empties the buffer and withholds ready.
    always_ff @(posedge clk_i) begin
        if (!sreset_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            ready_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: rtl/rtl_xor_unmask.sv
// Receive side of the XOR masking path: recovers B = masked ^ key, tags the last
// beat of each frame and hands the result to a two-entry skid buffer.
module rtl_xor_unmask
    import rtl_xor_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FRAME_LEN  = DEFAULT_FRAME_LEN
) (
    input  logic                  i__clk,
    input  logic                  i__sreset_n,
    input  logic                  i__valid,
    output logic                  o__ready,
    input  logic [DATA_WIDTH-1:0] i__masked,
    input  logic [DATA_WIDTH-1:0] i__key,
    output logic                  o__valid,
    input  logic                  i__ready,
    output logic [DATA_WIDTH-1:0] o__dout,
    output logic                  o__last,
    output logic                  o__busy
);

    localparam int CNT_WIDTH = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(FRAME_LEN - 1);

    logic [CNT_WIDTH-1:0] beatCnt_q, beatCnt_d;
    state_t               state_q, state_d;
    logic                 push;
    logic                 isLast;
    logic [DATA_WIDTH:0]  inWord;
    logic [DATA_WIDTH:0]  headWord;

    assign push    = i__valid && o__ready;
    assign isLast  = (beatCnt_q == LAST_BEAT);
    assign inWord  = {isLast, i__masked ^ i__key};
    assign o__last = headWord[DATA_WIDTH];
    assign o__dout = headWord[DATA_WIDTH-1:0];
    assign o__busy = (state_q == ACTIVE);

    // Frame tracking advances only on accepted words; the last beat returns to IDLE.
    always_comb begin
        state_d   = state_q;
        beatCnt_d = beatCnt_q;
        if (push) begin
            if (isLast) begin
                beatCnt_d = '0;
                state_d   = IDLE;
            end else begin
                beatCnt_d = beatCnt_q + CNT_WIDTH'(1);
                state_d   = ACTIVE;
            end
        end
    end

    // Register the frame state; reset abandons any partial frame.
    always_ff @(posedge i__clk) begin
        if (!i__sreset_n) begin
            state_q   <= IDLE;
            beatCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            beatCnt_q <= beatCnt_d;
        end
    end

    rtl_xor_skid2 #(
        .WIDTH(DATA_WIDTH + 1)
    ) uSkid (
        .clk_i     (i__clk),
        .sreset_n_i(i__sreset_n),
        .valid_i   (i__valid),
        .ready_o   (o__ready),
        .data_i    (inWord),
        .valid_o   (o__valid),
        .ready_i   (i__ready),
        .data_o    (headWord)
    );

endmodule

// File: tb/tb_rtl_xor_unmask.sv
// Scoreboard bench for rtl_xor_unmask: stimulus queues hand-computed words,
// a negedge monitor pops and compares every output transfer.
module tb_rtl_xor_unmask;

    localparam int DW = 10;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          sresetN;
    logic          inValid;
    logic          outReady;
    logic [DW-1:0] inMasked;
    logic [DW-1:0] inKey;
    logic          outValid;
    logic          downReady;
    logic [DW-1:0] outDout;
    logic          outLast;
    logic          outBusy;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    tbBeat = 0;

    logic [DW-1:0] frameMaskA [8] = '{10'h155, 10'h154, 10'h157, 10'h156,
                                      10'h151, 10'h150, 10'h153, 10'h152};
    logic [DW-1:0] frameMaskB [8] = '{10'h2AA, 10'h2AB, 10'h2A8, 10'h2A9,
                                      10'h2AE, 10'h2AF, 10'h2AC, 10'h2AD};
    logic [DW-1:0] ppMasked [10] = '{10'h001, 10'h3FF, 10'h2AA, 10'h0F0, 10'h123,
                                     10'h200, 10'h080, 10'h1C7, 10'h055, 10'h246};
    logic [DW-1:0] ppKey    [10] = '{10'h001, 10'h000, 10'h155, 10'h00F, 10'h321,
                                     10'h100, 10'h080, 10'h038, 10'h3AA, 10'h00C};
    logic [DW-1:0] ppExp    [10] = '{10'h000, 10'h3FF, 10'h3FF, 10'h0FF, 10'h202,
                                     10'h300, 10'h000, 10'h1FF, 10'h3FF, 10'h24A};

    rtl_xor_unmask dut (
        .i__clk     (clk),
        .i__sreset_n(sresetN),
        .i__valid   (inValid),
        .o__ready   (outReady),
        .i__masked  (inMasked),
        .i__key     (inKey),
        .o__valid   (outValid),
        .i__ready   (downReady),
        .o__dout    (outDout),
        .o__last    (outLast),
        .o__busy    (outBusy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offer one word until accepted, queue its expected result and check the frame flag.
    task automatic applyStimulus(input logic [DW-1:0] masked, input logic [DW-1:0] key,
                                 input logic [DW-1:0] expData, output int waits);
        logic accepted;
        logic expLast;
        inMasked = masked;
        inKey    = key;
        inValid  = 1'b1;
        accepted = 1'b0;
        waits    = 0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (outReady) begin
                accepted = 1'b1;
                expLast  = (tbBeat == 7);
                sb.push_back({expLast, expData});
                tbBeat = (tbBeat == 7) ? 0 : tbBeat + 1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
        if (!accepted) begin
            checkOutput("accept timeout", 32'd0, 32'd1);
        end else begin
            checkOutput("busy", {31'd0, outBusy}, {31'd0, tbBeat != 0});
        end
    endtask

    // Wait for every queued word to leave the DUT, then confirm the buffer is empty.
    task automatic waitDrain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("drain left", sb.size(), 32'd0);
        checkOutput("valid after drain", {31'd0, outValid}, 32'd0);
    endtask

    // Hold reset for a number of edges, clear the scoreboard and release.
    task automatic doReset(input int cycles);
        sresetN = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        sb.delete();
        tbBeat  = 0;
        sresetN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        beat_t e;
        if (sresetN && outValid && downReady) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected output got 0x%0h expected none", outDout);
            end else begin
                e = sb.pop_front();
                checkOutput("dout", {22'd0, outDout}, {22'd0, e.data});
                checkOutput("last", {31'd0, outLast}, {31'd0, e.last});
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    // Directed test sequence.
    initial begin
        int w;
        sresetN   = 1'b0;
        inValid   = 1'b0;
        inMasked  = '0;
        inKey     = '0;
        downReady = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset valid", {31'd0, outValid}, 32'd0);
        checkOutput("reset dout", {22'd0, outDout}, 32'd0);
        checkOutput("reset last", {31'd0, outLast}, 32'd0);
        checkOutput("reset busy", {31'd0, outBusy}, 32'd0);
        checkOutput("reset ready", {31'd0, outReady}, 32'd0);
        sresetN = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("release ready", {31'd0, outReady}, 32'd1);
        checkOutput("release valid", {31'd0, outValid}, 32'd0);
        checkOutput("release busy", {31'd0, outBusy}, 32'd0);

        $display("[TB] single word");
        downReady = 1'b1;
        applyStimulus(10'h3A5, 10'h0F0, 10'h355, w);
        checkOutput("single valid", {31'd0, outValid}, 32'd1);
        checkOutput("single dout", {22'd0, outDout}, 32'h355);
        checkOutput("single last", {31'd0, outLast}, 32'd0);
        waitDrain();

        $display("[TB] full frame");
        doReset(1);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(frameMaskA[k], 10'(k), 10'h155, w);
        end
        waitDrain();

        $display("[TB] backpressure");
        doReset(1);
        downReady = 1'b0;
        applyStimulus(10'h2AA, 10'h0FF, 10'h255, w);
        applyStimulus(10'h100, 10'h001, 10'h101, w);
        inMasked = 10'h3FF;
        inKey    = 10'h000;
        inValid  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp ready", {31'd0, outReady}, 32'd0);
            checkOutput("bp frozen dout", {22'd0, outDout}, 32'h255);
            checkOutput("bp frozen last", {31'd0, outLast}, 32'd0);
            @(posedge clk);
            #1;
        end
        downReady = 1'b1;
        applyStimulus(10'h3FF, 10'h000, 10'h3FF, w);
        checkOutput("bp third waits", w, 32'd1);
        waitDrain();

        $display("[TB] push and pop together");
        doReset(1);
        downReady = 1'b1;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(ppMasked[k], ppKey[k], ppExp[k], w);
            checkOutput("pp waits", w, 32'd0);
            checkOutput("pp valid", {31'd0, outValid}, 32'd1);
            checkOutput("pp ready", {31'd0, outReady}, 32'd1);
        end
        waitDrain();

        $display("[TB] mid-frame reset");
        doReset(1);
        downReady = 1'b1;
        applyStimulus(10'h011, 10'h010, 10'h001, w);
        @(posedge clk);
        #1;
        downReady = 1'b0;
        applyStimulus(10'h022, 10'h020, 10'h002, w);
        applyStimulus(10'h033, 10'h030, 10'h003, w);
        checkOutput("pre-reset ready", {31'd0, outReady}, 32'd0);
        sresetN = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        tbBeat = 0;
        checkOutput("mid reset valid", {31'd0, outValid}, 32'd0);
        checkOutput("mid reset busy", {31'd0, outBusy}, 32'd0);
        sresetN = 1'b1;
        @(posedge clk);
        #1;
        downReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(frameMaskB[k], 10'(k), 10'h2AA, w);
        end
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
